// File: rtl/vc_credit_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vc_credit_tx (plus package noc_params_pkg)                   |
// | Description : Credit-based link transmitter for a virtual-channel router   |
// |               output port. Keeps one credit counter and one allocation     |
// |               FSM (FREE/RESERVED/ACTIVE/DRAIN) per downstream VC, forwards |
// |               legal flits through one register stage and flags protocol    |
// |               violations on a sticky error output.                         |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               data_i/valid_i/vc_i/ready_o  - flit input from crossbar      |
// |               data_o/valid_o/vc_o          - registered link output        |
// |               credit_valid_i/credit_vc_i   - credit return from downstream |
// |               vc_claim_i/vc_claim_id_i     - VC allocator claim            |
// |               credit_avail_o, vc_free_o    - per-VC status vectors         |
// |               error_o                      - sticky protocol error         |
// | Option      : VC_CREDIT_BYPASS_EN - a credit returned in the same cycle    |
// |               may be used immediately by a send on that VC.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package noc_params_pkg;
  localparam int VC_DEPTH = 4;
  localparam int VC_NUM   = 4;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t flit_label;
    logic [31:0] data;
  } flit_t;
endpackage

module vc_credit_tx
  import noc_params_pkg::*;
#(
  parameter int BUFFER_SIZE = VC_DEPTH,
  parameter int N_VC        = VC_NUM,
  localparam int VC_SIZE    = $clog2(N_VC)
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              data_i,
  input  logic               valid_i,
  input  logic [VC_SIZE-1:0] vc_i,
  output logic               ready_o,
  output flit_t              data_o,
  output logic               valid_o,
  output logic [VC_SIZE-1:0] vc_o,
  input  logic               credit_valid_i,
  input  logic [VC_SIZE-1:0] credit_vc_i,
  input  logic               vc_claim_i,
  input  logic [VC_SIZE-1:0] vc_claim_id_i,
  output logic [N_VC-1:0]    credit_avail_o,
  output logic [N_VC-1:0]    vc_free_o,
  output logic               error_o
);

  localparam int                c_cnt_w      = $clog2(BUFFER_SIZE + 1);
  localparam logic [c_cnt_w-1:0] c_credit_max = c_cnt_w'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    S_FREE     = 2'd0,
    S_RESERVED = 2'd1,
    S_ACTIVE   = 2'd2,
    S_DRAIN    = 2'd3
  } vc_state_t;

  logic [N_VC-1:0][c_cnt_w-1:0] w_credit;
  logic [N_VC-1:0]              w_reserved;
  logic [N_VC-1:0]              w_active;
  logic [N_VC-1:0]              w_err_vc;

  flit_label_t w_lbl;
  logic        w_is_head;
  logic        w_legal;
  logic        w_accept;
  logic        w_send;
  logic        w_bad_flit;

  flit_t              r_data;
  logic               r_valid;
  logic [VC_SIZE-1:0] r_vc;
  logic               r_error;

`ifdef VC_CREDIT_BYPASS_EN
  // A credit arriving this cycle on the target VC covers a send from an empty counter.
  assign ready_o = (w_credit[vc_i] != '0) || (credit_valid_i && (credit_vc_i == vc_i));
`else
  assign ready_o = (w_credit[vc_i] != '0);
`endif

  // Heads must open a reserved VC; body/tail must continue an active packet.
  assign w_lbl      = data_i.flit_label;
  assign w_is_head  = (w_lbl == HEAD) || (w_lbl == HEADTAIL);
  assign w_legal    = w_is_head ? w_reserved[vc_i] : w_active[vc_i];
  assign w_accept   = valid_i && ready_o;
  assign w_send     = w_accept && w_legal;
  assign w_bad_flit = w_accept && !w_legal;

  for (genvar v = 0; v < N_VC; v++) begin : g_vc
    logic [c_cnt_w-1:0] r_credit;
    logic [c_cnt_w-1:0] w_credit_next;
    vc_state_t          r_state;
    vc_state_t          w_state_mid;
    vc_state_t          w_state_next;
    logic               w_dec;
    logic               w_inc;
    logic               w_claim;
    logic               w_cr_err;
    logic               w_claim_err;

    assign w_dec   = w_send && (vc_i == VC_SIZE'(v));
    assign w_inc   = credit_valid_i && (credit_vc_i == VC_SIZE'(v));
    assign w_claim = vc_claim_i && (vc_claim_id_i == VC_SIZE'(v));

    // Simultaneous send and return cancel; a net return onto a full counter overflows.
    always_comb begin
      w_credit_next = r_credit;
      w_cr_err      = 1'b0;
      if (w_inc && !w_dec) begin
        if (r_credit == c_credit_max) begin
          w_cr_err = 1'b1;
        end else begin
          w_credit_next = r_credit + c_cnt_w'(1);
        end
      end else if (w_dec && !w_inc) begin
        w_credit_next = r_credit - c_cnt_w'(1);
      end
    end

    // A VC leaves DRAIN on the same edge its counter becomes full again, so the
    // HEADTAIL/TAIL transition is resolved first and the drain check applied after.
    always_comb begin
      w_state_mid = r_state;
      w_claim_err = 1'b0;
      if (w_dec) begin
        case (r_state)
          S_RESERVED: w_state_mid = (w_lbl == HEADTAIL) ? S_DRAIN : S_ACTIVE;
          S_ACTIVE:   if (w_lbl == TAIL) w_state_mid = S_DRAIN;
          default:    w_state_mid = r_state;
        endcase
      end
      if (w_claim) begin
        if (r_state == S_FREE) begin
          w_state_mid = S_RESERVED;
        end else begin
          w_claim_err = 1'b1;
        end
      end
      w_state_next = w_state_mid;
      if ((w_state_mid == S_DRAIN) && (w_credit_next == c_credit_max)) begin
        w_state_next = S_FREE;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_credit <= c_credit_max;
        r_state  <= S_FREE;
      end else begin
        r_credit <= w_credit_next;
        r_state  <= w_state_next;
      end
    end

    assign w_credit[v]       = r_credit;
    assign w_reserved[v]     = (r_state == S_RESERVED);
    assign w_active[v]       = (r_state == S_ACTIVE);
    assign w_err_vc[v]       = w_cr_err || w_claim_err;
    assign credit_avail_o[v] = (r_credit != '0);
    assign vc_free_o[v]      = (r_state == S_FREE);
  end

  // Link register: data/vc hold their last value when nothing is forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_vc    <= '0;
      r_error <= 1'b0;
    end else begin
      r_valid <= w_send;
      if (w_send) begin
        r_data <= data_i;
        r_vc   <= vc_i;
      end
      r_error <= r_error || w_bad_flit || (|w_err_vc);
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign vc_o    = r_vc;
  assign error_o = r_error;

endmodule

`default_nettype wire
